// File: rtl/pablo_mem_ctrl_if.sv
// pablo_mem_ctrl_if: external memory req/ack port.
// master drives req/we/addr/wdata/be; slave returns rdata and a one-cycle ack.
interface pablo_mem_ctrl_if #(
  parameter int AW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic [31:0]   rdata;
  logic          ack;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack
  );
endinterface

// File: rtl/pablo_mem_ctrl.sv
// pablo_mem_ctrl: turns core rd/wr strobes into a req/ack memory transaction,
// stalls the core on hlt, and flags a sticky bus_err on ack timeout.
// Ports: clk, res (async, active-low); core side daddr/datao/wr/rd/be in,
// datai/hlt/bus_err out; mem is the external port (master modport).
// Option: define PABLO_WBUF_EN for a one-entry posted write buffer.
module pablo_mem_ctrl #(
  parameter int          AW       = 32,
  parameter logic [7:0]  TIMEOUT  = 8'd255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic [AW-1:0]    daddr,
  input  logic [31:0]      datao,
  input  logic             wr,
  input  logic             rd,
  input  logic [3:0]       be,
  output logic [31:0]      datai,
  output logic             hlt,
  output logic             bus_err,
  pablo_mem_ctrl_if.master mem
);

`ifdef PABLO_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic       acc;
  logic       tmo;
  logic       posted;

  assign acc     = rd | wr;
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  // Abort on the cycle the count reaches TIMEOUT, so req is high
  // for exactly TIMEOUT cycles; an ack in that cycle still wins.
  assign tmo     = (state == REQ) && !mem.ack
                && (cnt_inc == TIMEOUT);
  // A write in flight is posted only when the buffer is enabled.
  assign posted  = WBUF & mem.we;

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (acc) state_nxt = REQ;
      REQ:     if (mem.ack || tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A posted drain hides its own stall; only a new access
  // arriving meanwhile sees hlt.
  always_comb begin
    hlt     = 1'b0;
    mem.req = 1'b0;
    unique case (1'b1)
      state == IDLE: hlt = rd | (wr & ~WBUF);
      state == REQ: begin
        mem.req = 1'b1;
        hlt     = posted ? acc : 1'b1;
      end
      state == DONE: hlt = posted & acc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      mem.we    <= 1'b0;
      mem.addr  <= '0;
      mem.wdata <= '0;
      mem.be    <= '0;
      datai     <= '0;
      bus_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            mem.we    <= wr;
            mem.addr  <= daddr;
            mem.wdata <= datao;
            mem.be    <= be;
          end
        end
        REQ: begin
          cnt <= cnt_inc;
          if (mem.ack) begin
            if (!mem.we) datai <= mem.rdata;
          end else if (tmo) begin
            bus_err <= 1'b1;
            if (!mem.we) datai <= ERR_DATA;
          end
        end
        DONE:    cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

endmodule
